// File: rtl/tob_snapshot_launcher.sv
// Live L1 top-of-book with frozen-snapshot launch of the strategy core over ap_start/ap_done.
// Latency: update at edge k -> snapshot + core_start after edge k+1 when idle and book valid.
// Backpressure: none; updates always accepted out of reset and coalesce while the core is busy.
module tob_snapshot_launcher #(
    parameter int PRICE_W     = 32,
    parameter int QTY_W       = 32,
    parameter int STRONG_QTY  = 100,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic               upd_side,
    input  logic [PRICE_W-1:0] upd_price,
    input  logic [QTY_W-1:0]   upd_qty,
    output logic [PRICE_W-1:0] best_bid_price,
    output logic [PRICE_W-1:0] best_ask_price,
    output logic [QTY_W-1:0]   best_bid_qty,
    output logic [QTY_W-1:0]   best_ask_qty,
    output logic               bid_queue_strong,
    output logic               ask_queue_strong,
    output logic               core_start,
    input  logic               core_done,
    output logic               book_crossed,
    output logic               timeout_err,
    output logic [15:0]        snap_cnt
);

    localparam int WCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
    localparam logic [QTY_W-1:0] STRONG_TH = QTY_W'(STRONG_QTY);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state;
    logic [WCW-1:0]     wait_cnt;
    logic [PRICE_W-1:0] live_bid_price;
    logic [PRICE_W-1:0] live_ask_price;
    logic [QTY_W-1:0]   live_bid_qty;
    logic [QTY_W-1:0]   live_ask_qty;
    logic               dirty;
    logic               upd_fire;
    logic               both_sides;
    logic               live_crossed;
    logic               launch_ok;
    logic               do_launch;

    assign upd_ready    = ap_rst_n;
    assign upd_fire     = upd_valid & upd_ready;
    assign both_sides   = (live_bid_qty != '0) && (live_ask_qty != '0);
    assign live_crossed = both_sides && (live_bid_price >= live_ask_price);
    assign launch_ok    = dirty && both_sides && (live_bid_price < live_ask_price);
    assign do_launch    = (state == S_IDLE) && launch_ok;

    // An emptied side carries price 0 so stale prices never leak into a later snapshot.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            live_bid_price <= '0;
            live_ask_price <= '0;
            live_bid_qty   <= '0;
            live_ask_qty   <= '0;
        end else if (upd_fire) begin
            if (upd_side) begin
                live_ask_price <= (upd_qty == '0) ? '0 : upd_price;
                live_ask_qty   <= upd_qty;
            end else begin
                live_bid_price <= (upd_qty == '0) ? '0 : upd_price;
                live_bid_qty   <= upd_qty;
            end
        end
    end

    // A same-edge update wins over the launch clear so it gets its own relaunch.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dirty        <= 1'b0;
            book_crossed <= 1'b0;
        end else begin
            book_crossed <= live_crossed;
            if (upd_fire) begin
                dirty <= 1'b1;
            end else if (do_launch) begin
                dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= S_IDLE;
            wait_cnt         <= '0;
            core_start       <= 1'b0;
            snap_cnt         <= '0;
            timeout_err      <= 1'b0;
            best_bid_price   <= '0;
            best_ask_price   <= '0;
            best_bid_qty     <= '0;
            best_ask_qty     <= '0;
            bid_queue_strong <= 1'b0;
            ask_queue_strong <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch_ok) begin
                        best_bid_price   <= live_bid_price;
                        best_ask_price   <= live_ask_price;
                        best_bid_qty     <= live_bid_qty;
                        best_ask_qty     <= live_ask_qty;
                        bid_queue_strong <= (live_bid_qty >= STRONG_TH);
                        ask_queue_strong <= (live_ask_qty >= STRONG_TH);
                        core_start       <= 1'b1;
                        snap_cnt         <= snap_cnt + 16'd1;
                        state            <= S_START;
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tob_snapshot_launcher.sv
// Directed bench for tob_snapshot_launcher: expected launches queued at stimulus time,
// checked by an independent monitor whenever core_start is seen.
module tb_tob_snapshot_launcher;

    localparam int TO = 32;

    typedef struct packed {
        logic [31:0] bp;
        logic [31:0] ap;
        logic [31:0] bq;
        logic [31:0] aq;
        logic        bs;
        logic        as_s;
        logic [15:0] cnt;
    } snap_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic        upd_side = 1'b0;
    logic [31:0] upd_price = '0;
    logic [31:0] upd_qty = '0;
    logic [31:0] best_bid_price;
    logic [31:0] best_ask_price;
    logic [31:0] best_bid_qty;
    logic [31:0] best_ask_qty;
    logic        bid_queue_strong;
    logic        ask_queue_strong;
    logic        core_start;
    logic        core_done = 1'b0;
    logic        book_crossed;
    logic        timeout_err;
    logic [15:0] snap_cnt;

    int n_chk = 0;
    int n_fail = 0;
    snap_t sb[$];

    tob_snapshot_launcher #(
        .PRICE_W(32), .QTY_W(32), .STRONG_QTY(100), .TIMEOUT_CYC(TO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_side(upd_side),
        .upd_price(upd_price), .upd_qty(upd_qty),
        .best_bid_price(best_bid_price), .best_ask_price(best_ask_price),
        .best_bid_qty(best_bid_qty), .best_ask_qty(best_ask_qty),
        .bid_queue_strong(bid_queue_strong), .ask_queue_strong(ask_queue_strong),
        .core_start(core_start), .core_done(core_done),
        .book_crossed(book_crossed), .timeout_err(timeout_err), .snap_cnt(snap_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic snap_t mk(input logic [31:0] bp, input logic [31:0] ap,
                                 input logic [31:0] bq, input logic [31:0] aq,
                                 input logic bs, input logic as_s, input logic [15:0] cnt);
        snap_t s;
        s.bp = bp; s.ap = ap; s.bq = bq; s.aq = aq; s.bs = bs; s.as_s = as_s; s.cnt = cnt;
        return s;
    endfunction

    function automatic snap_t cur();
        return mk(best_bid_price, best_ask_price, best_bid_qty, best_ask_qty,
                  bid_queue_strong, ask_queue_strong, snap_cnt);
    endfunction

    // Monitor: every cycle with core_start high must match the oldest queued launch.
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && core_start === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_core_start", 160'(core_start), 160'(0));
            end else begin
                chk("launch_snapshot", 160'(cur()), 160'(sb.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic upd(input logic side, input logic [31:0] price, input logic [31:0] qty);
        upd_valid = 1'b1;
        upd_side  = side;
        upd_price = price;
        upd_qty   = qty;
        @(posedge ap_clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic done_pulse();
        core_done = 1'b1;
        @(posedge ap_clk);
        #1;
        core_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        snap_t held;
        // Reset state
        #12;
        chk("rst_snapshot", 160'(cur()), 160'(0));
        chk("rst_upd_ready", 160'(upd_ready), 160'(0));
        chk("rst_core_start", 160'(core_start), 160'(0));
        chk("rst_flags", 160'({book_crossed, timeout_err}), 160'(0));
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        #1;
        chk("upd_ready_out_of_reset", 160'(upd_ready), 160'(1));
        idle(1);

        // 1: basic launch
        upd(1'b0, 32'd100, 32'd150);
        sb.push_back(mk(32'd100, 32'd101, 32'd150, 32'd50, 1'b1, 1'b0, 16'd1));
        upd(1'b1, 32'd101, 32'd50);
        idle(2);
        done_pulse();

        // 2: locked book blocks launch until ask improves
        upd(1'b0, 32'd101, 32'd150);
        idle(2);
        chk("locked_book_crossed", 160'(book_crossed), 160'(1));
        chk("locked_no_start", 160'(core_start), 160'(0));
        sb.push_back(mk(32'd101, 32'd102, 32'd150, 32'd50, 1'b1, 1'b0, 16'd2));
        upd(1'b1, 32'd102, 32'd50);
        idle(2);
        chk("unlocked_book_crossed", 160'(book_crossed), 160'(0));
        done_pulse();

        // 3: coalescing of updates during WAIT
        sb.push_back(mk(32'd101, 32'd102, 32'd200, 32'd50, 1'b1, 1'b0, 16'd3));
        upd(1'b0, 32'd101, 32'd200);
        idle(2);
        held = mk(32'd101, 32'd102, 32'd200, 32'd50, 1'b1, 1'b0, 16'd3);
        upd(1'b1, 32'd105, 32'd120);
        chk("wait_snapshot_frozen_1", 160'(cur()), 160'(held));
        upd(1'b0, 32'd103, 32'd99);
        upd(1'b1, 32'd104, 32'd300);
        chk("wait_snapshot_frozen_3", 160'(cur()), 160'(held));
        chk("wait_no_start", 160'(core_start), 160'(0));
        sb.push_back(mk(32'd103, 32'd104, 32'd99, 32'd300, 1'b0, 1'b1, 16'd4));
        done_pulse();
        idle(2);
        done_pulse();

        // 4: timeout after TO cycles in WAIT
        sb.push_back(mk(32'd100, 32'd104, 32'd100, 32'd300, 1'b1, 1'b1, 16'd5));
        upd(1'b0, 32'd100, 32'd100);
        idle(TO);
        chk("timeout_not_yet", 160'(timeout_err), 160'(0));
        idle(2);
        chk("timeout_set", 160'(timeout_err), 160'(1));
        sb.push_back(mk(32'd100, 32'd105, 32'd100, 32'd80, 1'b1, 1'b0, 16'd6));
        upd(1'b1, 32'd105, 32'd80);
        idle(2);
        done_pulse();
        chk("timeout_sticky", 160'(timeout_err), 160'(1));

        // 5: empty ask side blocks launch
        upd(1'b1, 32'd200, 32'd0);
        idle(4);
        chk("empty_ask_no_start", 160'(core_start), 160'(0));
        chk("empty_ask_not_crossed", 160'(book_crossed), 160'(0));
        sb.push_back(mk(32'd100, 32'd106, 32'd100, 32'd10, 1'b1, 1'b0, 16'd7));
        upd(1'b1, 32'd106, 32'd10);
        idle(2);
        done_pulse();

        // 6: reset mid-WAIT with a pending update
        sb.push_back(mk(32'd101, 32'd106, 32'd100, 32'd10, 1'b1, 1'b0, 16'd8));
        upd(1'b0, 32'd101, 32'd100);
        idle(2);
        upd(1'b1, 32'd107, 32'd10);
        ap_rst_n = 1'b0;
        #1;
        chk("midwait_rst_snapshot", 160'(cur()), 160'(0));
        chk("midwait_rst_ctrl", 160'({upd_ready, core_start, book_crossed, timeout_err}), 160'(0));
        idle(2);
        ap_rst_n = 1'b1;
        idle(8);
        chk("post_rst_no_start", 160'({core_start, snap_cnt}), 160'(0));

        chk("all_launches_seen", 160'(sb.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
